unified_mem_arbiter: RTL

Sequencer and arbiter that shares one single-ported unified instruction/data memory between the fetch stage and the memory stage of the pipelined RV32 core. It grants one requester at a time, holds the granted transaction on the memory port until the memory handshakes, and returns read data with a one-cycle completion pulse. It drives per-requester stall signals that feed the hazard unit. Data accesses have priority over fetch because they belong to the older instruction.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_timeout_ctr.sv | 40 ++++
 rtl/unified_mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the unified memory arbiter: sequencer state
// encoding and the default width / timeout values used by the top level.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    localparam int ARB_XLEN    = 32;
    localparam int ARB_TIMEOUT = 16;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Wait-cycle counter with sticky error flag for the unified memory arbiter.
// Counts cycles a granted transaction spends waiting on the memory and
// flags expiry on the cycle in which the LIMIT-th wait cycle occurs.
module arb_timeout_ctr
    import arb_pkg::*;
#(
    parameter int LIMIT = ARB_TIMEOUT
)(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire,
    output logic err
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign expire = enable & (count == CW'(LIMIT - 1));

    // Count stalled cycles, restart on each new grant, latch error until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (clear) begin
                count <= '0;
            end else if (enable) begin
                count <= count + CW'(1);
            end
            if (expire) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified instruction/data memory arbiter for the pipelined RV32 core.
// Shares one single-ported memory between fetch and memory stage; data
// requests win because they belong to the older instruction.
// Optional feature macro: ARB_TIMEOUT_EN (wait-cycle timeout + sticky mem_err).
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int XLEN    = ARB_XLEN,
    parameter int TIMEOUT = ARB_TIMEOUT
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_done,
    output logic            if_stall,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_done,
    output logic            dm_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            mem_err
);

    arb_state_t state;
    arb_state_t state_next;

    logic if_elig;
    logic dm_elig;
    logic grant_if;
    logic grant_dm;
    logic busy;
    logic complete;
    logic expire;
    logic finish;

    // A requester whose done is pulsing still shows its old request, so it
    // sits out this idle cycle instead of being granted a second time.
    assign if_elig  = if_req & ~if_done;
    assign dm_elig  = dm_req & ~dm_done;
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    assign busy     = (state != IDLE);
    assign complete = busy & mem_ready;
    assign finish   = complete | expire;

`ifdef ARB_TIMEOUT_EN
    arb_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant_if | grant_dm),
        .enable (busy & ~mem_ready),
        .expire (expire),
        .err    (mem_err)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b0;
    assign mem_err        = 1'b0;
`endif

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection with data priority, and return to idle on completion
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        case (state)
            IDLE: begin
                if (dm_elig) begin
                    state_next = DATA;
                    grant_dm   = 1'b1;
                end else if (if_elig) begin
                    state_next = FETCH;
                    grant_if   = 1'b1;
                end
            end
            FETCH, DATA: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory port latches, read-data return and one-cycle done pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (finish) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (finish && state == FETCH) begin
                if_done  <= 1'b1;
                if_rdata <= complete ? mem_rdata : '0;
            end
            if (finish && state == DATA) begin
                dm_done  <= 1'b1;
                dm_rdata <= (complete && !mem_we) ? mem_rdata : '0;
            end
        end
    end

endmodule
